// File: rtl/maze_frame_writer_if.sv
// Bus bundle between the maze frame writer and its surroundings:
// render control (start, vsync_pulse, wall_color), tile-map and pattern
// ROM fetch (tile_addr/tile_data, pattern_addr/pattern_data) and the
// frame-RAM write port plus bank select and status (wr_*, rd_bank, busy, done).
// slave  : the writer itself.
// master : whatever drives control and serves the ROMs (SoC glue / bench).
interface maze_frame_writer_if;
  logic       start;
  logic       vsync_pulse;
  logic [7:0] wall_color;
  logic [9:0] tile_addr;
  logic [3:0] tile_data;
  logic [6:0] pattern_addr;
  logic [7:0] pattern_data;
  logic       wr_en;
  logic [15:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_bank;
  logic       rd_bank;
  logic       busy;
  logic       done;

  modport slave (
    input  start, vsync_pulse, wall_color, tile_data, pattern_data,
    output tile_addr, pattern_addr, wr_en, wr_addr, wr_data,
           wr_bank, rd_bank, busy, done
  );

  modport master (
    output start, vsync_pulse, wall_color, tile_data, pattern_data,
    input  tile_addr, pattern_addr, wr_en, wr_addr, wr_data,
           wr_bank, rd_bank, busy, done
  );
endinterface

// File: rtl/maze_frame_writer.sv
// Producer side of the ping-pong maze frame RAM.
// On start, walks the 30x33 tile map column-block by column-block, fetches
// each tile id and its 8-pixel column slice, and writes 8 pixels per slice
// into the back bank at address x*264+y (strictly sequential). When the
// frame is complete it waits for a frame boundary before swapping banks.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : maze_frame_writer_if.slave (control, ROM fetch, RAM write)
module maze_frame_writer #(
  parameter int         XMAX      = 240,
  parameter int         YLEN      = 264,
  parameter int         TROWS     = YLEN / 8,
  parameter logic [7:0] DOT_COLOR = 8'b1111_1110
) (
  input  logic            clk,
  input  logic            rst,
  maze_frame_writer_if.slave bus
);

  localparam logic [5:0] TY_LAST = 6'(TROWS - 1);
  localparam logic [7:0] X_LAST  = 8'(XMAX - 1);
  localparam logic [9:0] TSTEP   = 10'(TROWS);

  typedef enum logic [2:0] {IDLE, FETCH_T, FETCH_P, WRITE, SWAP_WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [5:0]  ty_q, ty_d;
  logic [2:0]  py_q, py_d;
  logic [15:0] addr_q, addr_d;
  logic [9:0]  tbase_q, tbase_d;   // (x>>3)*TROWS, kept incrementally
  logic [3:0]  tid_q, tid_d;
  logic [7:0]  pat_q, pat_d;
  logic        bank_q, bank_d;
  logic        done_q, done_d;

  logic [7:0]  pat_cur;
  logic        pix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      ty_q    <= '0;
      py_q    <= '0;
      addr_q  <= '0;
      tbase_q <= '0;
      tid_q   <= '0;
      pat_q   <= '0;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ty_q    <= ty_d;
      py_q    <= py_d;
      addr_q  <= addr_d;
      tbase_q <= tbase_d;
      tid_q   <= tid_d;
      pat_q   <= pat_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ty_d    = ty_q;
    py_d    = py_q;
    addr_d  = addr_q;
    tbase_d = tbase_q;
    tid_d   = tid_q;
    pat_d   = pat_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = FETCH_T;
        x_d     = '0;
        ty_d    = '0;
        addr_d  = '0;
        tbase_d = '0;
      end
      FETCH_T: state_d = FETCH_P;
      FETCH_P: begin
        tid_d   = bus.tile_data;
        py_d    = '0;
        state_d = WRITE;
      end
      WRITE: begin
        addr_d = addr_q + 16'd1;
        py_d   = py_q + 3'd1;
        if (py_q == 3'd0) pat_d = bus.pattern_data;
        if (py_q == 3'd7) begin
          if (ty_q < TY_LAST) begin
            ty_d    = ty_q + 6'd1;
            state_d = FETCH_T;
          end else if (x_q < X_LAST) begin
            ty_d    = '0;
            x_d     = x_q + 8'd1;
            // crossing into the next 8-column tile block
            if (x_q[2:0] == 3'd7) tbase_d = tbase_q + TSTEP;
            state_d = FETCH_T;
          end else begin
            state_d = SWAP_WAIT;
            done_d  = 1'b1;
          end
        end
      end
      SWAP_WAIT: begin
        // a strobe coincident with the done pulse belongs to the frame
        // still on screen, so only a later one may swap
        if (bus.vsync_pulse && !done_q) begin
          bank_d  = ~bank_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pattern_data is only valid on the first WRITE cycle; later pixels of
  // the slice come from the captured copy
  assign pat_cur = (py_q == 3'd0) ? bus.pattern_data : pat_q;
  assign pix     = pat_cur[py_q];

  always_comb begin
    bus.wr_data = 8'h00;
    if (state_q == WRITE && pix) begin
      if (tid_q >= 4'd14)     bus.wr_data = DOT_COLOR;
      else if (tid_q != 4'd0) bus.wr_data = bus.wall_color;
    end
  end

  assign bus.wr_en        = (state_q == WRITE);
  assign bus.wr_addr      = addr_q;
  assign bus.tile_addr    = tbase_q + {4'b0, ty_q};
  assign bus.pattern_addr = (state_q == FETCH_P) ? {bus.tile_data, x_q[2:0]}
                                                 : {tid_q, x_q[2:0]};
  assign bus.wr_bank      = bank_q;
  assign bus.rd_bank      = ~bank_q;
  assign bus.busy         = (state_q == FETCH_T) || (state_q == FETCH_P) ||
                            (state_q == WRITE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_maze_frame_writer.sv
module tb_maze_frame_writer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maze_frame_writer_if bus();
  maze_frame_writer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int         addr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  int nvec = 0, nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] tmap [0:1023];
  logic [7:0] prom [0:127];
  logic [7:0] fmem [0:63359];

  // ROM models: data valid the cycle after the address
  always @(posedge clk) begin
    bus.tile_data    <= tmap[bus.tile_addr];
    bus.pattern_data <= prom[bus.pattern_addr];
  end

  // monitor-owned state
  int          wcount = 0, ordererr = 0, busyerr = 0, bankerr = 0;
  int          zcyc = 0, lastcyc = 0, donecnt = 0, donecyc = 0;
  logic        busy_at_done = 1'b0;
  logic [15:0] nexp = '0;
  bit          wsel = 1'b0;
  // main-owned state
  logic        exp_bank = 1'b0;
  bit          frame1 = 1'b1;
  logic [7:0]  c0 = 8'h00, c1 = 8'h03, c2 = 8'h00;

  // wall colour switches after write 29999 of the first frame
  assign bus.wall_color = !frame1 ? c2 : (wsel ? c1 : c0);

  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (bus.wr_addr != nexp) ordererr++;
      nexp = bus.wr_addr + 16'd1;
      if (!bus.busy) busyerr++;
      if (bus.wr_bank !== exp_bank) bankerr++;
      if (bus.wr_addr < 16'd63360) fmem[bus.wr_addr] = bus.wr_data;
      if (bus.wr_addr == 16'd0) zcyc = cyc;
      lastcyc = cyc;
      wcount++;
      if (bus.wr_addr == 16'd29999) wsel = 1'b1;
    end else if (!bus.busy) nexp = '0;
    if (bus.done) begin
      donecnt++;
      donecyc      = cyc;
      busy_at_done = bus.busy;
    end
  end

  // reference pixel: straight from the map/pattern/colour rules
  function automatic logic [7:0] model_pix(int a, logic [7:0] wc);
    int x, y, t;
    logic [7:0] p;
    x = a / 264;
    y = a % 264;
    t = int'(tmap[(x / 8) * 33 + y / 8]);
    p = prom[t * 8 + x % 8];
    if (t == 0 || !p[y % 8]) return 8'h00;
    if (t >= 14) return 8'hFE;
    return wc;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start(output int k);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = cyc;
  endtask

  vec_t tbl [9];

  initial begin
    int  kst, base, bad, w2;
    bit  got;

    tbl[0] = '{0,     8'h00, "origin"};
    tbl[1] = '{794,   8'h00, "dot_above"};
    tbl[2] = '{795,   8'hFE, "dot_a"};
    tbl[3] = '{796,   8'hFE, "dot_b"};
    tbl[4] = '{797,   8'h00, "dot_below"};
    tbl[5] = '{61504, 8'h03, "wall_first"};
    tbl[6] = '{63359, 8'h03, "wall_last"};
    tbl[7] = '{61503, 8'h00, "wall_above"};
    tbl[8] = '{61240, 8'h00, "wall_left"};

    bus.start = 1'b0;
    bus.vsync_pulse = 1'b0;
    for (int i = 0; i < 1024; i++) tmap[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 128; i++)  prom[i] = 8'($urandom);
    tmap[0] = 4'd14;
    tmap[29*33+32] = 4'd1;
    tmap[29*33+31] = 4'd0;
    tmap[28*33+32] = 4'd0;
    for (int c = 0; c < 8; c++) begin
      prom[14*8+c] = 8'h00;
      prom[8+c]    = 8'hFF;
    end
    prom[14*8+3] = 8'h18;
    c0 = 8'($urandom_range(4, 255));
    c2 = 8'($urandom_range(4, 255));

    #12;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_tile_addr", bus.tile_addr, 0);
    chk("rst_pattern_addr", bus.pattern_addr, 0);
    chk("rst_wr_bank", bus.wr_bank, 0);
    chk("rst_rd_bank", bus.rd_bank, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- frame 1 into bank 0 ----------------
    pulse_start(kst);
    chk("busy_first_fetch", bus.busy, 1);
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk); #1;
      if (wcount >= 500) got = 1;
    end
    chk("reach_write_500", got, 1);
    pulse_start(base);             // must be ignored mid-frame
    got = 0;
    for (int i = 0; i < 80000 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1;
    end
    chk("done_seen", got, 1);
    bus.vsync_pulse = 1'b1;        // coincident with done: no swap
    @(negedge clk);
    bus.vsync_pulse = 1'b0;
    chk("no_swap_with_done", bus.wr_bank, 0);
    pulse_start(base);             // after done: ignored
    repeat (3) @(negedge clk);
    chk("idle_after_done_start", {bus.busy, bus.wr_en}, 0);
    bus.vsync_pulse = 1'b1;
    #1 chk("bank_before_edge", bus.wr_bank, 0);
    @(posedge clk); #1;
    chk("bank_swapped_wr", bus.wr_bank, 1);
    chk("bank_swapped_rd", bus.rd_bank, 0);
    @(negedge clk) bus.vsync_pulse = 1'b0;

    chk("f1_writes", wcount, 63360);
    chk("f1_order", ordererr, 0);
    chk("f1_busy_on_write", busyerr, 0);
    chk("f1_bank", bankerr, 0);
    chk("f1_first_write_cyc", zcyc - kst, 2);
    chk("f1_last_write_cyc", lastcyc - kst, 79199);
    chk("f1_done_cyc", donecyc - kst, 79200);
    chk("f1_done_count", donecnt, 1);
    chk("f1_busy_at_done", busy_at_done, 0);
    bad = 0;
    for (int a = 0; a < 63360; a++)
      if (fmem[a] !== model_pix(a, (a < 30000) ? c0 : c1)) bad++;
    chk("f1_pixels", bad, 0);
    for (int i = 0; i < 9; i++) chk(tbl[i].name, fmem[tbl[i].addr], tbl[i].exp);

    // ---------------- frame 2 into bank 1, reset mid-frame ----------------
    frame1 = 0;
    exp_bank = 1'b1;
    base = wcount;
    pulse_start(kst);
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk); #1;
      if (wcount - base >= 1000) got = 1;
    end
    chk("reach_write_1000", got, 1);
    chk("f2_first_write_cyc", zcyc - kst, 2);
    #1 rst = 1'b0;
    exp_bank = 1'b0;
    #1;
    chk("mid_rst_wr_en", bus.wr_en, 0);
    chk("mid_rst_wr_addr", bus.wr_addr, 0);
    chk("mid_rst_wr_bank", bus.wr_bank, 0);
    chk("mid_rst_rd_bank", bus.rd_bank, 1);
    chk("mid_rst_busy", bus.busy, 0);
    w2 = wcount;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_writes", wcount - w2, 0);
    chk("f2_writes", wcount - base, 1000);
    chk("mid_rst_no_done", donecnt, 1);
    bad = 0;
    for (int a = 0; a < 1000; a++) if (fmem[a] !== model_pix(a, c2)) bad++;
    chk("f2_pixels", bad, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_bank", bus.wr_bank, 0);

    // ---------------- restart after reset ----------------
    base = wcount;
    pulse_start(kst);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (wcount - base >= 40) got = 1;
    end
    chk("reach_restart_40", got, 1);
    chk("f3_first_write_cyc", zcyc - kst, 2);
    bad = 0;
    for (int a = 0; a < 40; a++) if (fmem[a] !== model_pix(a, c2)) bad++;
    chk("f3_pixels", bad, 0);
    chk("all_order", ordererr, 0);
    chk("all_bank", bankerr, 0);
    chk("all_busy", busyerr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/maze_frame_writer.md
Name: maze_frame_writer

Overview:
- Producer side of the ping-pong frame RAM that the pixel-rendering path reads for maze_color.
- On a start pulse, walks the 30x33 tile map and expands each 8x8 tile into 8-bit pixels.
- Writes every pixel into the back bank using the same linear mapping the reader uses: address = x*264 + y, with x in 0..239 and y in 0..263.
- On completion, waits for a frame boundary before swapping banks, so the display never tears.

Parameters:
- XMAX, 240: pixel columns (x extent).
- YLEN, 264: pixel rows stored per column (y extent after the 24-line offset).
- TROWS, 33: tile rows, equal to YLEN/8.
- DOT_COLOR, 8'b11111110: colour for dot and pellet tiles (CRM).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to render a frame; honoured only in IDLE
- vsync_pulse  in  1  one-cycle frame-boundary strobe
- wall_color  in  8  colour for wall tiles (ids 1..13)
- tile_addr  out  10  tile-map index = (x>>3)*TROWS + ty
- tile_data  in  4  tile id, valid the cycle after tile_addr is presented
- pattern_addr  out  7  {tile_id, x[2:0]}
- pattern_data  in  8  tile slice for one column; bit i = pixel at y offset i; valid the cycle after pattern_addr is presented
- wr_en  out  1  frame-RAM write strobe
- wr_addr  out  16  frame-RAM address
- wr_data  out  8  pixel colour
- wr_bank  out  1  bank being written
- rd_bank  out  1  bank the reader displays; always ~wr_bank (combinational)
- busy  out  1  high from the first FETCH_T cycle through the last write
- done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (async, rst=0): state IDLE; wr_en, wr_addr, wr_data, tile_addr, pattern_addr, wr_bank, busy and done all 0; rd_bank therefore 1.
- Reset asserted mid-frame: wr_en drops immediately with no further writes; the frame is abandoned and wr_bank returns to 0.
- States: IDLE, FETCH_T, FETCH_P, WRITE, SWAP_WAIT.
- IDLE: start=1 goes to FETCH_T with x=0, ty=0 and the address counter at 0.
- FETCH_T (1 cycle): drive tile_addr, then go to FETCH_P.
- FETCH_P (1 cycle): latch tile_data as tile_id; drive pattern_addr={tile_data, x[2:0]}; go to WRITE with py=0.
- WRITE (8 cycles, py 0..7):
  - On py=0, capture pattern_data into the pattern register. Outputs on that cycle use the live value.
  - wr_en=1 on every WRITE cycle.
  - wr_addr = running counter, incremented by 1 per write.
  - wr_data = 0 when pattern bit py is 0.
  - When the bit is 1: DOT_COLOR if tile_id is 14 or 15, wall_color if tile_id is 1..13.
  - Tile id 0 always writes 0.
- After py=7:
  - If ty<32: increment ty and go to FETCH_T.
  - Else if x<239: set ty=0, increment x, go to FETCH_T.
  - Else: go to SWAP_WAIT and pulse done.
- Address order: writes are strictly sequential, 0..63359, each written exactly once per frame. No multiplier on the write path; tile_addr may use an incremental counter or a multiply.
- Timing, with start sampled at edge k:
  - First FETCH_T on cycle k+1; first write on cycle k+3.
  - 10 cycles per group, 7920 groups.
  - Last write on cycle k+79200; done=1 on cycle k+79201.
- SWAP_WAIT: on vsync_pulse, toggle wr_bank (rd_bank follows) and go to IDLE. A vsync_pulse on the same cycle done asserts does not swap; only a later pulse swaps.
- start in any state other than IDLE is ignored and is not queued.
- vsync_pulse outside SWAP_WAIT is ignored.
- wall_color is sampled live per write; changing it mid-frame affects only the later pixels.

Test Plan:
- Reset check: assert rst=0 mid-cycle -> all outputs 0 and rd_bank=1 asynchronously.
- Blank frame: all tile ids 0, start at cycle k -> exactly 63360 writes with data 0x00 to addresses 0..63359 with no gaps or repeats; done on cycle k+79201 only; busy low on that cycle.
- Dot slice: tile (0,0)=14, pattern(14, col 3)=0x18, all else 0 -> addresses 795 and 796 get 0xFE; all other addresses get 0x00.
- Wall corner: tile (29,32)=1, pattern all 0xFF, wall_color=0x03 -> addresses 232*264+256 .. 239*264+263 (block corners 61504 and 63359) get 0x03; all other addresses get 0x00.
- Handshake:
  - Start pulsed at write 500 -> ignored, no restart.
  - After done, start pulsed -> ignored.
  - vsync_pulse -> wr_bank 0->1 and rd_bank 1->0 on the next edge; state IDLE.
  - A following start renders into bank 1.
- Mid-frame reset: rst=0 at write 1000 -> wr_en=0 immediately and no done pulse; wr_bank=0. A new start after release begins again at wr_addr 0.
